// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Upstream stage of the serial ROM loader path. Synchronises an external,
//   asynchronous 3-wire serial stream (frame enable, bit clock, data) into the
//   i_clk domain. It deserialises the stream MSB-first into DATA_WIDTH-bit words
//   and presents each word downstream with a load/strobe/ack handshake.
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_ser_load    async frame enable (high for a whole ROM image)
//   i_ser_clk     async serial bit clock, data sampled on its rising edge
//   i_ser_data    async serial data, MSB of each word first
//   i_ack         one-cycle pulse: presented word has been consumed
//   o_load        synchronised frame enable to downstream
//   o_data_out    word presented to downstream
//   o_sck         word-valid strobe, high while o_data_out is unconsumed
//   o_word_count  words acked in the current frame (wraps)
//   o_overrun     sticky: a complete word was dropped while one was pending
//   o_frame_err   sticky: frame ended with a partial word
module serial_word_receiver #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_ser_load,
   input  logic                   i_ser_clk,
   input  logic                   i_ser_data,
   input  logic                   i_ack,
   output logic                   o_load,
   output logic [DATA_WIDTH-1:0]  o_data_out,
   output logic                   o_sck,
   output logic [COUNT_WIDTH-1:0] o_word_count,
   output logic                   o_overrun,
   output logic                   o_frame_err
);

   localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StPresent
   } state_e;

   // Synchroniser flops. All three inputs use the same two-flop depth so that
   // the data bit stays aligned with its bit clock; the third stage on load
   // and clk provides edge detection.
   logic r_load_s1, r_load_s2, r_load_s3;
   logic r_clk_s1, r_clk_s2, r_clk_s3;
   logic r_data_s1, r_data_s2;

   state_e                 r_state, w_state_next;
   logic [BitCntW-1:0]     r_bit_cnt, w_bit_cnt_next;
   logic [DATA_WIDTH-1:0]  r_shift, w_shift_next;
   logic [DATA_WIDTH-1:0]  r_data, w_data_next;
   logic                   r_sck, w_sck_next;
   logic [COUNT_WIDTH-1:0] r_count, w_count_next;
   logic                   r_overrun, w_overrun_next;
   logic                   r_frame_err, w_frame_err_next;

   logic                   w_load_rise;
   logic                   w_load_fall;
   logic                   w_clk_rise;
   logic                   w_word_done;
   logic [DATA_WIDTH-1:0]  w_shifted;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_load_s1 <= 1'b0;
         r_load_s2 <= 1'b0;
         r_load_s3 <= 1'b0;
         r_clk_s1  <= 1'b0;
         r_clk_s2  <= 1'b0;
         r_clk_s3  <= 1'b0;
         r_data_s1 <= 1'b0;
         r_data_s2 <= 1'b0;
      end else begin
         r_load_s1 <= i_ser_load;
         r_load_s2 <= r_load_s1;
         r_load_s3 <= r_load_s2;
         r_clk_s1  <= i_ser_clk;
         r_clk_s2  <= r_clk_s1;
         r_clk_s3  <= r_clk_s2;
         r_data_s1 <= i_ser_data;
         r_data_s2 <= r_data_s1;
      end
   end

   assign w_load_rise = r_load_s2 & ~r_load_s3;
   assign w_load_fall = ~r_load_s2 & r_load_s3;
   assign w_clk_rise  = r_clk_s2 & ~r_clk_s3;
   assign w_shifted   = {r_shift[DATA_WIDTH-2:0], r_data_s2};
   assign w_word_done = w_clk_rise && (r_bit_cnt == LastBit);

   always_comb begin
      w_state_next     = r_state;
      w_bit_cnt_next   = r_bit_cnt;
      w_shift_next     = r_shift;
      w_data_next      = r_data;
      w_sck_next       = r_sck;
      w_count_next     = r_count;
      w_overrun_next   = r_overrun;
      w_frame_err_next = r_frame_err;

      unique case (r_state)
         StIdle: begin
            w_sck_next = 1'b0;
            if (w_load_rise) begin
               w_bit_cnt_next   = '0;
               w_shift_next     = '0;
               w_count_next     = '0;
               w_overrun_next   = 1'b0;
               w_frame_err_next = 1'b0;
               w_state_next     = StShift;
            end
         end

         StShift: begin
            if (w_clk_rise) begin
               w_shift_next   = w_shifted;
               w_bit_cnt_next = r_bit_cnt + BitCntW'(1);
               if (w_word_done) begin
                  w_bit_cnt_next = '0;
                  w_data_next    = w_shifted;
                  w_sck_next     = 1'b1;
                  w_state_next   = StPresent;
               end
            end
         end

         StPresent: begin
            // The next word keeps shifting in while the current one waits.
            if (w_clk_rise) begin
               w_shift_next   = w_shifted;
               w_bit_cnt_next = w_word_done ? '0 : r_bit_cnt + BitCntW'(1);
            end
            if (i_ack) begin
               w_count_next = r_count + COUNT_WIDTH'(1);
            end
            if (i_ack && w_word_done) begin
               // Hand-over with no low cycle on sck.
               w_data_next = w_shifted;
            end else if (i_ack) begin
               w_sck_next   = 1'b0;
               w_state_next = StShift;
            end else if (w_word_done) begin
               w_overrun_next = 1'b1;
            end
         end

         default: begin
            w_state_next = StIdle;
            w_sck_next   = 1'b0;
         end
      endcase

      // Frame end overrides everything: partial bits are discarded but the last
      // presented word and the count stay visible.
      if (w_load_fall) begin
         w_sck_next     = 1'b0;
         w_state_next   = StIdle;
         w_bit_cnt_next = '0;
         w_shift_next   = '0;
         w_data_next    = r_data;
         w_count_next   = r_count;
         if (r_bit_cnt != '0) begin
            w_frame_err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_sck       <= 1'b0;
         r_count     <= '0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_bit_cnt   <= w_bit_cnt_next;
         r_shift     <= w_shift_next;
         r_data      <= w_data_next;
         r_sck       <= w_sck_next;
         r_count     <= w_count_next;
         r_overrun   <= w_overrun_next;
         r_frame_err <= w_frame_err_next;
      end
   end

   assign o_load       = r_load_s2;
   assign o_data_out   = r_data;
   assign o_sck        = r_sck;
   assign o_word_count = r_count;
   assign o_overrun    = r_overrun;
   assign o_frame_err  = r_frame_err;

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Upstream stage of the serial ROM loader path.
- Receives an external, asynchronous 3-wire serial stream (frame enable, bit clock, data) and synchronises it into the clk domain.
- Deserialises the stream MSB-first into DATA_WIDTH-bit words.
- Presents each word to the downstream ROM stream loader with a load/strobe/ack handshake. It drives that stage's load, input_data and sck inputs and consumes its ack output.

Parameters:
- DATA_WIDTH, 16, word width in bits; shift register and data_out width.
- COUNT_WIDTH, 16, width of the accepted-word counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ser_load  input  1  async frame enable from the external host; high for a whole ROM image.
- ser_clk  input  1  async serial bit clock; data is sampled on its rising edge.
- ser_data  input  1  async serial data, MSB of each word first.
- ack  input  1  one-cycle pulse from downstream: the presented word has been consumed.
- load  output  1  synchronised frame enable to downstream.
- data_out  output  DATA_WIDTH  word presented to downstream.
- sck  output  1  word-valid strobe; high while data_out holds an unconsumed word.
- word_count  output  COUNT_WIDTH  words acked in the current frame.
- overrun  output  1  sticky: a complete word was dropped because the previous word was still pending.
- frame_err  output  1  sticky: the frame ended with a partial word.

Behaviour:
- Reset (async assert): all state clears to zero immediately. This covers load, sck, data_out, word_count, overrun, frame_err, the bit counter, the shift register and the synchronisers. The FSM goes to IDLE.
- Synchronisers: ser_load, ser_clk and ser_data each pass through 2 flops with identical depth, so data stays aligned with its clock.
- Clock edge detect: a third flop on ser_clk produces a one-cycle clk_rise.
- Host timing: ser_clk high and low phases are each at least 3 clk cycles. Faster input is out of scope.
- load output: equals the synchronised ser_load, 2 cycles after the pin.
- FSM state IDLE: nothing shifts and sck=0. When synchronised ser_load rises:
  - clear the bit counter, word_count, overrun and frame_err;
  - go to SHIFT.
- FSM state SHIFT: on each clk_rise, shift_reg <= {shift_reg[DATA_WIDTH-2:0], data_s} and increment the bit counter. On the DATA_WIDTH-th bit:
  - data_out <= completed word;
  - sck <= 1 on the next cycle;
  - bit counter wraps to 0;
  - go to PRESENT.
- FSM state PRESENT: shifting of the next word continues (double buffering). sck stays high until ack is sampled high.
  - On ack: sck <= 0 the next cycle, word_count <= word_count+1, go to SHIFT.
  - Simultaneous ack and a new word completing: count the old word, load the new word into data_out, and keep sck high with no low cycle. Stay in PRESENT.
  - Word completes with no ack that cycle: drop the new word, leave data_out unchanged, set overrun.
- ack outside PRESENT is ignored.
- word_count wraps modulo 2^COUNT_WIDTH.
- Synchronised ser_load falls in any state:
  - sck <= 0, go to IDLE;
  - set frame_err if the bit counter is non-zero;
  - discard partial bits;
  - leave data_out and word_count holding their values.
- A new rising load restarts cleanly. Downstream resets its address on that same load edge.
- Reset mid-frame: everything clears. If ser_load is still high after reset deasserts, its synchronised rise starts a new frame.
- Sticky flags: overrun and frame_err clear only on reset or a load rise.

Test Plan:
- Single word: ser_load=1, shift 0xA5C3 MSB-first; ack 5 cycles after sck rises -> data_out=0xA5C3, sck high until the cycle after ack, word_count=1, overrun=0, frame_err=0.
- Burst: 8 words 0x0001..0x0008 with prompt acks -> eight sck pulses, data values in order, word_count=8, no flags set.
- Overrun: word 0x1111 then 0x2222 with ack held low throughout -> data_out stays 0x1111, overrun=1. After ack, word_count=1.
- Simultaneous: ack pulse lands on the completion cycle of the next word 0xBEEF -> sck has no low cycle, data_out=0xBEEF, word_count increments by 1.
- Partial frame: 5 bits sent, then ser_load low -> frame_err=1, sck=0, FSM in IDLE. A new ser_load rise clears frame_err and word_count.
- Async reset: assert reset mid-word with sck high -> all outputs 0 immediately, before the next clk edge. After release, a full word 0x7E81 is received correctly.
